// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg: shared types and helpers for the PLL lock sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    localparam int RELOCK_W = 8;

    // Bits needed to count 0 .. max(a,b,c)-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff: single-bit two-flop synchronizer, async active-high reset. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer: PLL reset/lock-wait/qualify/run sequencer with retry,
// sticky fault and relock counting. Optional: PLL_LOCK_LOSS_PULSE_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 16
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                restart,
    output logic                pll_rst,
    output logic                clk_ready,
    output logic                fault,
    output logic [2:0]          state_o,
    output logic [RELOCK_W-1:0] relock_cnt
`ifdef PLL_LOCK_LOSS_PULSE_EN
    ,
    output logic                lock_lost
`endif
);

    // Never narrower than the longest interval requires, even if CNT_W is set too small.
    localparam int CNT_NEED  = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int CNT_WIDTH = (CNT_NEED > CNT_W) ? CNT_NEED : CNT_W;
    localparam int RETRY_W   = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

    pll_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [RETRY_W-1:0]    retries_q, retries_d;
    logic [RELOCK_W-1:0]   relock_q, relock_d;
    logic                  lock_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lock_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            retries_q <= '0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            relock_q  <= relock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        relock_d  = relock_q;

        if (restart) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d     = '0;
                        retries_d = retries_q + 1'b1;
                        state_d   = (retries_q == RETRY_LAST) ? ST_FAULT : ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_STABLE: begin
                    // A glitch restarts the lock wait without costing a retry.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        retries_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        if (relock_q != {RELOCK_W{1'b1}}) begin
                            relock_d = relock_q + 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    state_d = ST_FAULT;
                end

                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pll_rst    = (state_q == ST_HOLD) || (state_q == ST_FAULT);
    assign clk_ready  = (state_q == ST_RUN);
    assign fault      = (state_q == ST_FAULT);
    assign state_o    = state_q;
    assign relock_cnt = relock_q;

`ifdef PLL_LOCK_LOSS_PULSE_EN
    logic lost_q;
    logic lost_d;

    assign lost_d = (state_q == ST_RUN) && !lock_s && !restart;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lost_q <= 1'b0;
        end else begin
            lost_q <= lost_d;
        end
    end

    assign lock_lost = lost_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer: scoreboard bench for the PLL lock sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pll_lock_sequencer;

    localparam int S_HOLD   = 0;
    localparam int S_WAIT   = 1;
    localparam int S_STABLE = 2;
    localparam int S_RUN    = 3;
    localparam int S_FAULT  = 4;
    localparam int N_LOSS   = 260;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart    = 1'b0;
    logic       pll_rst;
    logic       clk_ready;
    logic       fault;
    logic [2:0] state_o;
    logic [7:0] relock_cnt;
`ifdef PLL_LOCK_LOSS_PULSE_EN
    logic       lock_lost;
`endif

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .CNT_W               (16)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .clk_ready  (clk_ready),
        .fault      (fault),
        .state_o    (state_o),
        .relock_cnt (relock_cnt)
`ifdef PLL_LOCK_LOSS_PULSE_EN
        ,
        .lock_lost  (lock_lost)
`endif
    );

    always #5 refclk = ~refclk;

    typedef struct {
        int cyc;
        int st;
        int rl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   lost_hi = 0;
    int   lost_rise = 0;

    // Cycle index seen at a negedge = index of the next rising edge since reset release.
    always @(posedge refclk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_tr(input int c, input int s, input int r);
        exp_t e;
        e.cyc = c;
        e.st  = s;
        e.rl  = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge refclk); while (cyc < c);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge refclk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d transitions still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at a negedge; asserts rst mid-cycle and checks the async response.
    task automatic do_reset();
        #2 rst = 1'b1;
        restart = 1'b0;
        #1;
        chk("rst_state",     state_o,    S_HOLD);
        chk("rst_pll_rst",   pll_rst,    1);
        chk("rst_clk_ready", clk_ready,  0);
        chk("rst_fault",     fault,      0);
        chk("rst_relock",    relock_cnt, 0);
`ifdef PLL_LOCK_LOSS_PULSE_EN
        chk("rst_lock_lost", lock_lost,  0);
`endif
        repeat (3) @(negedge refclk);
        rst = 1'b0;
    endtask

    // Monitor: each state change pops one expected transition.
    initial begin
        logic [2:0] prev_st;
        exp_t       e;
        prev_st = 3'd0;
        forever begin
            @(negedge refclk);
            if (rst) begin
                prev_st = 3'd0;
            end else if (state_o !== prev_st) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transition: state %0d -> %0d at cycle %0d, expected no change",
                             prev_st, state_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("tr_cycle",   cyc,        e.cyc);
                    chk("tr_state",   state_o,    e.st);
                    chk("relock_cnt", relock_cnt, e.rl);
                    chk("pll_rst",    pll_rst,    (e.st == S_HOLD) || (e.st == S_FAULT));
                    chk("clk_ready",  clk_ready,  e.st == S_RUN);
                    chk("fault",      fault,      e.st == S_FAULT);
                end
                prev_st = state_o;
            end
        end
    end

`ifdef PLL_LOCK_LOSS_PULSE_EN
    initial begin
        logic prev_lost;
        prev_lost = 1'b0;
        forever begin
            @(negedge refclk);
            if (lock_lost === 1'b1) begin
                lost_hi++;
                if (!prev_lost) lost_rise++;
            end
            prev_lost = (lock_lost === 1'b1);
        end
    end
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int rl;

        // Lock from power-up, lock loss in RUN, restart coincident with loss.
        pll_locked = 1'b1;
        @(negedge refclk);
        do_reset();
        expect_tr(4, S_WAIT, 0);
        expect_tr(5, S_STABLE, 0);
        expect_tr(13, S_RUN, 0);
        expect_tr(23, S_HOLD, 1);
        expect_tr(27, S_WAIT, 1);
        expect_tr(28, S_STABLE, 1);
        expect_tr(36, S_RUN, 1);
        wait_cyc(20); pll_locked = 1'b0;
        wait_cyc(25); pll_locked = 1'b1;
        expect_tr(43, S_HOLD, 1);
        expect_tr(47, S_WAIT, 1);
        expect_tr(48, S_STABLE, 1);
        wait_cyc(40); pll_locked = 1'b0;
        wait_cyc(42); restart = 1'b1;
        wait_cyc(43); restart = 1'b0; pll_locked = 1'b1;
        wait_cyc(51);
        drain(4);
`ifdef PLL_LOCK_LOSS_PULSE_EN
        chk("lock_lost_no_pulse_on_restart", lost_hi, 1);
`endif
        chk("pre_reset_state", state_o, S_STABLE);
        do_reset();

        // Glitchy lock during STABLE.
        expect_tr(4, S_WAIT, 0);
        expect_tr(5, S_STABLE, 0);
        expect_tr(10, S_WAIT, 0);
        expect_tr(13, S_STABLE, 0);
        expect_tr(21, S_RUN, 0);
        wait_cyc(7);  pll_locked = 1'b0;
        wait_cyc(10); pll_locked = 1'b1;
        wait_cyc(25);
        drain(4);

        // Timeout to fault, fault ignores lock, restart recovers.
        pll_locked = 1'b0;
        do_reset();
        expect_tr(4, S_WAIT, 0);
        expect_tr(36, S_HOLD, 0);
        expect_tr(40, S_WAIT, 0);
        expect_tr(72, S_FAULT, 0);
        wait_cyc(80);
        for (int i = 0; i < 20; i++) begin
            pll_locked = ~pll_locked;
            wait_cyc(81 + i);
        end
        wait_cyc(100); pll_locked = 1'b1;
        expect_tr(111, S_HOLD, 0);
        expect_tr(115, S_WAIT, 0);
        expect_tr(116, S_STABLE, 0);
        expect_tr(124, S_RUN, 0);
        wait_cyc(110); restart = 1'b1;
        wait_cyc(111); restart = 1'b0;
        wait_cyc(130);
        drain(4);

        // Relock counter saturation.
        pll_locked = 1'b1;
        do_reset();
        lost_hi   = 0;
        lost_rise = 0;
        expect_tr(4, S_WAIT, 0);
        expect_tr(5, S_STABLE, 0);
        expect_tr(13, S_RUN, 0);
        for (int i = 0; i < N_LOSS; i++) begin
            d  = 20 + 20 * i;
            rl = (i + 1 > 255) ? 255 : i + 1;
            expect_tr(d + 3, S_HOLD, rl);
            expect_tr(d + 7, S_WAIT, rl);
            expect_tr(d + 8, S_STABLE, rl);
            expect_tr(d + 16, S_RUN, rl);
            wait_cyc(d);     pll_locked = 1'b0;
            wait_cyc(d + 1); pll_locked = 1'b1;
        end
        wait_cyc(20 + 20 * N_LOSS + 2);
        drain(4);
        chk("relock_saturated", relock_cnt, 255);
`ifdef PLL_LOCK_LOSS_PULSE_EN
        chk("lock_lost_high_cycles", lost_hi, N_LOSS);
        chk("lock_lost_pulses", lost_rise, N_LOSS);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences bring-up of the fabric PLL, which is driven from the 50 MHz board clock and produces the 1 MHz slow clock.
- Holds the PLL in reset for a fixed interval, then waits for lock with a timeout and qualifies lock as stable.
- Only then asserts clk_ready, which gates downstream ADC/UART logic.
- Monitors for loss of lock, re-runs the sequence automatically, and enters a sticky fault after repeated lock failures.

Parameters:
- RST_HOLD_CYCLES, 64: refclk cycles pll_rst is held high per attempt.
- LOCK_TIMEOUT_CYCLES, 50000: max refclk cycles in WAIT_LOCK before retry (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before RUN.
- MAX_RETRIES, 4: consecutive timeouts before FAULT.
- CNT_W, 16: width of the shared cycle counter; must hold max(above)-1.

Ports:
- refclk  in  1  PLL reference clock; the only clock of this block.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  raw PLL locked flag, asynchronous to refclk.
- restart  in  1  single-cycle request to re-run the sequence; also clears FAULT.
- pll_rst  out  1  drives the PLL rst input.
- clk_ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- state_o  out  3  current state encoding, for debug.
- relock_cnt  out  8  saturating count of lock losses seen in RUN.

Behaviour:
- Lock input: pll_locked passes through a 2-flop synchronizer (lock_s), giving 2-cycle latency.
- Outputs: all Moore outputs, decoded from the registered state.
- Reset values: state=HOLD, pll_rst=1, clk_ready=0, fault=0, state_o=0, relock_cnt=0, retries=0, counter=0, synchronizer flops=0.
- State encoding: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- HOLD:
  - pll_rst=1; counter increments from 0.
  - At counter==RST_HOLD_CYCLES-1, go to WAIT_LOCK and clear the counter.
  - pll_rst is high exactly RST_HOLD_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - lock_s=1: go to STABLE, counter=0.
  - Else, at counter==LOCK_TIMEOUT_CYCLES-1: retries++. If retries reaches MAX_RETRIES, go to FAULT; otherwise go to HOLD.
- STABLE:
  - lock_s=0: go back to WAIT_LOCK with counter=0; retries are not incremented.
  - At counter==LOCK_STABLE_CYCLES-1 with lock_s=1: go to RUN and clear retries.
- RUN:
  - clk_ready=1.
  - lock_s=0: go to HOLD and increment relock_cnt (saturates at 255).
  - clk_ready drops on the next edge.
- FAULT:
  - pll_rst=1, fault=1.
  - Stays in FAULT, ignoring lock_s, until restart or rst.
- restart:
  - In any state, go to HOLD, counter=0, retries=0; relock_cnt is kept.
  - restart has priority over every other transition in the same cycle; a simultaneous lock loss in RUN does not increment relock_cnt.
- Counter: clears on every state change and never wraps. Illegal state encodings recover to HOLD.
- Reset: assertion mid-operation returns everything to reset values immediately (asynchronous). Deassertion is assumed synchronized externally.

Optional Feature:
- Macro: PLL_LOCK_LOSS_PULSE_EN.
- When defined: adds output lock_lost (1 bit). It is a 1-cycle registered pulse on the edge where RUN→HOLD occurs due to lock_s=0; it does not pulse on restart; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package pll_seq_pkg: state enum (3-bit, encodings as above), RELOCK_W=8, and a function computing the counter width from the parameters.
- Sub-module sync_2ff: a generic single-bit 2-flop synchronizer with async active-high reset, instantiated for pll_locked.

Test Plan:
Bench parameters for all scenarios: RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2; cycle 0 = first edge after rst deassert.
- Lock from power-up: pll_locked=1 throughout -> pll_rst high cycles 0-3; STABLE at cycle 5; clk_ready rises at cycle 13; relock_cnt=0.
- Glitchy lock: pll_locked drops for 3 cycles mid-STABLE -> returns to WAIT_LOCK, clk_ready stays 0, retries unchanged. After relock, clk_ready rises 8+1 cycles after lock_s re-asserts.
- Lock loss in RUN: pll_locked low for 5 cycles -> clk_ready falls 3 cycles after the drop, pll_rst high 4 cycles, relock_cnt=1; RUN is re-entered once lock returns.
- Timeout to fault: pll_locked=0 forever -> two HOLD/WAIT_LOCK attempts of 4+32 cycles each, then fault=1 and pll_rst=1. Toggling pll_locked has no effect; restart pulse -> HOLD, fault=0.
- Priority and reset: restart coincident with lock loss in RUN -> HOLD, relock_cnt unchanged. rst asserted mid-STABLE -> all outputs return to reset values without waiting for a clock edge.
- Saturation: 260 lock-loss events in RUN -> relock_cnt holds at 255. With PLL_LOCK_LOSS_PULSE_EN defined, exactly 260 single-cycle lock_lost pulses are seen.
